atm_keypad_frontend: RTL and testbench

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

---
 rtl/atm_keypad_frontend.sv | 213 +++++++++++++++++++++
 tb/tb_atm_keypad_frontend.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: collects a 4-digit PIN, a transaction selection and a
// decimal amount from keypad strobes, and tracks the controller's status.
module atm_keypad_frontend #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_AMT_DIGITS = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cardInserted,
   input  logic        keyValid,
   input  logic [3:0]  keyCode,
   input  logic        incorrectPin,
   input  logic        warning,
   input  logic        block,
   input  logic        balanceUpdated,
   input  logic        insufficientFunds,
   output logic        receivedCard,
   output logic [3:0]  digit,
   output logic        stbDigit,
   output logic        transType,
   output logic        stbTransaction,
   output logic [31:0] amount,
   output logic        stbAmount,
   output logic        locked
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(MAX_AMT_DIGITS + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] AMT_MAX  = AW'(MAX_AMT_DIGITS);

   localparam logic [3:0] KEY_ENTER    = 4'hA;
   localparam logic [3:0] KEY_CLEAR    = 4'hB;
   localparam logic [3:0] KEY_DEPOSIT  = 4'hC;
   localparam logic [3:0] KEY_WITHDRAW = 4'hD;
   localparam logic [3:0] KEY_CANCEL   = 4'hE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PIN,
      S_WAIT_PIN,
      S_AMOUNT,
      S_DONE,
      S_LOCKED
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      pin_cnt, pin_cnt_nxt;
   logic [AW-1:0]   amt_cnt, amt_cnt_nxt;
   logic [31:0]     acc, acc_nxt;
   logic [TW-1:0]   tmr, tmr_nxt;
   logic            inc_q, warn_q;
   logic            cancel_hold, cancel_hold_nxt;

   logic [3:0]      digit_nxt;
   logic            stb_digit_nxt;
   logic            trans_type_nxt;
   logic            stb_trans_nxt;
   logic [31:0]     amount_nxt;
   logic            stb_amount_nxt;

   logic            key_digit, key_cancel, status_rise, done_evt, abort;

   // acc*10 + d, wrapping in 32-bit unsigned arithmetic
   function automatic logic [31:0] dec_shift(input logic [31:0] a, input logic [3:0] d);
      return (a << 3) + (a << 1) + {28'd0, d};
   endfunction

   assign key_digit   = keyValid && (keyCode <= 4'd9);
   assign key_cancel  = keyValid && (keyCode == KEY_CANCEL);
   assign status_rise = (incorrectPin && !inc_q) || (warning && !warn_q);
   assign done_evt    = balanceUpdated || insufficientFunds || (tmr == TMR_LAST);

   always_comb begin
      state_nxt       = state;
      pin_cnt_nxt     = pin_cnt;
      amt_cnt_nxt     = amt_cnt;
      acc_nxt         = acc;
      tmr_nxt         = '0;
      cancel_hold_nxt = cancel_hold;
      digit_nxt       = digit;
      stb_digit_nxt   = 1'b0;
      trans_type_nxt  = transType;
      stb_trans_nxt   = 1'b0;
      amount_nxt      = amount;
      stb_amount_nxt  = 1'b0;
      abort           = 1'b0;

      if (!cardInserted) begin
         state_nxt       = S_IDLE;
         pin_cnt_nxt     = '0;
         amt_cnt_nxt     = '0;
         acc_nxt         = '0;
         cancel_hold_nxt = 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               // after CANCEL the card must be pulled before a new session starts
               if (!cancel_hold) begin
                  state_nxt   = S_PIN;
                  pin_cnt_nxt = '0;
               end
            end
            S_PIN: begin
               if (key_cancel) begin
                  abort = 1'b1;
               end else if (key_digit) begin
                  digit_nxt     = keyCode;
                  stb_digit_nxt = 1'b1;
                  pin_cnt_nxt   = pin_cnt + 3'd1;
                  if (pin_cnt == 3'd3)
                     state_nxt = S_WAIT_PIN;
               end
            end
            S_WAIT_PIN: begin
               if (block) begin
                  state_nxt = S_LOCKED;
               end else if (status_rise) begin
                  state_nxt   = S_PIN;
                  pin_cnt_nxt = '0;
               end else if (key_cancel) begin
                  abort = 1'b1;
               end else if (keyValid && (keyCode == KEY_DEPOSIT || keyCode == KEY_WITHDRAW)) begin
                  trans_type_nxt = (keyCode == KEY_WITHDRAW);
                  stb_trans_nxt  = 1'b1;
                  state_nxt      = S_AMOUNT;
                  acc_nxt        = '0;
                  amt_cnt_nxt    = '0;
               end
            end
            S_AMOUNT: begin
               if (key_cancel) begin
                  abort = 1'b1;
               end else if (key_digit) begin
                  if (amt_cnt < AMT_MAX) begin
                     acc_nxt     = dec_shift(acc, keyCode);
                     amt_cnt_nxt = amt_cnt + AW'(1);
                  end
               end else if (keyValid && keyCode == KEY_CLEAR) begin
                  acc_nxt     = '0;
                  amt_cnt_nxt = '0;
               end else if (keyValid && keyCode == KEY_ENTER && amt_cnt != '0) begin
                  amount_nxt     = acc;
                  stb_amount_nxt = 1'b1;
                  state_nxt      = S_DONE;
               end
            end
            S_DONE: begin
               if (done_evt) begin
                  state_nxt   = S_WAIT_PIN;
                  acc_nxt     = '0;
                  amt_cnt_nxt = '0;
               end else if (key_cancel) begin
                  abort = 1'b1;
               end else begin
                  tmr_nxt = tmr + TW'(1);
               end
            end
            S_LOCKED: begin
               state_nxt = S_LOCKED;
            end
            default: state_nxt = S_IDLE;
         endcase

         if (abort) begin
            state_nxt       = S_IDLE;
            pin_cnt_nxt     = '0;
            amt_cnt_nxt     = '0;
            acc_nxt         = '0;
            cancel_hold_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         pin_cnt        <= '0;
         amt_cnt        <= '0;
         acc            <= '0;
         tmr            <= '0;
         inc_q          <= 1'b0;
         warn_q         <= 1'b0;
         cancel_hold    <= 1'b0;
         receivedCard   <= 1'b0;
         digit          <= '0;
         stbDigit       <= 1'b0;
         transType      <= 1'b0;
         stbTransaction <= 1'b0;
         amount         <= '0;
         stbAmount      <= 1'b0;
         locked         <= 1'b0;
      end else begin
         state          <= state_nxt;
         pin_cnt        <= pin_cnt_nxt;
         amt_cnt        <= amt_cnt_nxt;
         acc            <= acc_nxt;
         tmr            <= tmr_nxt;
         inc_q          <= incorrectPin;
         warn_q         <= warning;
         cancel_hold    <= cancel_hold_nxt;
         receivedCard   <= (state_nxt != S_IDLE);
         digit          <= digit_nxt;
         stbDigit       <= stb_digit_nxt;
         transType      <= trans_type_nxt;
         stbTransaction <= stb_trans_nxt;
         amount         <= amount_nxt;
         stbAmount      <= stb_amount_nxt;
         locked         <= (state_nxt == S_LOCKED);
      end
   end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend: a vector table walked cycle by cycle,
// then hand-written sequences for the DONE timeout and reset mid-transaction.
module tb_atm_keypad_frontend;

   localparam int TO = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cardInserted = 1'b0;
   logic        keyValid = 1'b0;
   logic [3:0]  keyCode = 4'h0;
   logic        incorrectPin = 1'b0;
   logic        warning = 1'b0;
   logic        block = 1'b0;
   logic        balanceUpdated = 1'b0;
   logic        insufficientFunds = 1'b0;
   logic        receivedCard;
   logic [3:0]  digit;
   logic        stbDigit;
   logic        transType;
   logic        stbTransaction;
   logic [31:0] amount;
   logic        stbAmount;
   logic        locked;

   always #5 clock = ~clock;

   atm_keypad_frontend #(.TIMEOUT_CYCLES(TO), .MAX_AMT_DIGITS(9)) dut (
      .clock(clock), .reset(reset), .cardInserted(cardInserted),
      .keyValid(keyValid), .keyCode(keyCode), .incorrectPin(incorrectPin),
      .warning(warning), .block(block), .balanceUpdated(balanceUpdated),
      .insufficientFunds(insufficientFunds), .receivedCard(receivedCard),
      .digit(digit), .stbDigit(stbDigit), .transType(transType),
      .stbTransaction(stbTransaction), .amount(amount), .stbAmount(stbAmount),
      .locked(locked)
   );

   // status bits packed as {incorrectPin, warning, block, balanceUpdated, insufficientFunds}
   typedef struct {
      logic        c;
      logic        k;
      logic [3:0]  kc;
      logic [4:0]  s;
      logic [41:0] exp;
   } vec_t;

   vec_t tbl[$];
   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [41:0] pk(input logic rc, input logic sd, input logic [3:0] dg,
                                      input logic st, input logic tt, input logic sa,
                                      input logic [31:0] amt, input logic lk);
      return {rc, sd, dg, st, tt, sa, amt, lk};
   endfunction

   function automatic logic [41:0] got();
      return {receivedCard, stbDigit, digit, stbTransaction, transType, stbAmount, amount, locked};
   endfunction

   task automatic add(input logic c, input logic k, input logic [3:0] kc, input logic [4:0] s,
                      input logic rc, input logic sd, input logic [3:0] dg, input logic st,
                      input logic tt, input logic sa, input logic [31:0] amt, input logic lk);
      vec_t v;
      v.c = c; v.k = k; v.kc = kc; v.s = s;
      v.exp = pk(rc, sd, dg, st, tt, sa, amt, lk);
      tbl.push_back(v);
   endtask

   task automatic step(input logic c, input logic k, input logic [3:0] kc, input logic [4:0] s);
      cardInserted = c;
      keyValid     = k;
      keyCode      = kc;
      {incorrectPin, warning, block, balanceUpdated, insufficientFunds} = s;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [41:0] want);
      logic [41:0] g;
      g = got();
      n_vec++;
      if (g !== want) begin
         n_bad++;
         $display("FAIL %s: outputs {rc,sd,dg,st,tt,sa,amt,lk} = %h, expected %h", nm, g, want);
      end
   endtask

   initial begin
      // card insert and first PIN
      add(1,0,4'h0,5'b00000, 1,0,4'd0,0,0,0,0,0);
      add(1,1,4'h1,5'b00000, 1,1,4'd1,0,0,0,0,0);
      add(1,1,4'h2,5'b00000, 1,1,4'd2,0,0,0,0,0);
      add(1,1,4'h3,5'b00000, 1,1,4'd3,0,0,0,0,0);
      add(1,1,4'h4,5'b00000, 1,1,4'd4,0,0,0,0,0);
      add(1,0,4'h0,5'b00000, 1,0,4'd4,0,0,0,0,0);
      // incorrectPin edge -> PIN again, digits 5..8
      add(1,0,4'h0,5'b10000, 1,0,4'd4,0,0,0,0,0);
      add(1,1,4'h5,5'b10000, 1,1,4'd5,0,0,0,0,0);
      add(1,1,4'h6,5'b10000, 1,1,4'd6,0,0,0,0,0);
      add(1,1,4'h7,5'b10000, 1,1,4'd7,0,0,0,0,0);
      add(1,1,4'h8,5'b10000, 1,1,4'd8,0,0,0,0,0);
      // block -> LOCKED, keys ignored, card removal -> IDLE
      add(1,0,4'h0,5'b10100, 1,0,4'd8,0,0,0,0,1);
      add(1,1,4'h1,5'b10100, 1,0,4'd8,0,0,0,0,1);
      add(1,1,4'hE,5'b10100, 1,0,4'd8,0,0,0,0,1);
      add(0,0,4'h0,5'b00000, 0,0,4'd8,0,0,0,0,0);
      add(0,1,4'h3,5'b00000, 0,0,4'd8,0,0,0,0,0);
      // new session, withdraw 250
      add(1,0,4'h0,5'b00000, 1,0,4'd8,0,0,0,0,0);
      add(1,1,4'h1,5'b00000, 1,1,4'd1,0,0,0,0,0);
      add(1,1,4'h2,5'b00000, 1,1,4'd2,0,0,0,0,0);
      add(1,1,4'h3,5'b00000, 1,1,4'd3,0,0,0,0,0);
      add(1,1,4'h4,5'b00000, 1,1,4'd4,0,0,0,0,0);
      add(1,1,4'hD,5'b00000, 1,0,4'd4,1,1,0,0,0);
      add(1,1,4'h2,5'b00000, 1,0,4'd4,0,1,0,0,0);
      add(1,1,4'h5,5'b00000, 1,0,4'd4,0,1,0,0,0);
      add(1,1,4'h0,5'b00000, 1,0,4'd4,0,1,0,0,0);
      add(1,1,4'hA,5'b00000, 1,0,4'd4,0,1,1,32'd250,0);
      add(1,0,4'h0,5'b00001, 1,0,4'd4,0,1,0,32'd250,0);
      // deposit: empty ENTER ignored, ten 9s saturate at nine digits
      add(1,1,4'hC,5'b00000, 1,0,4'd4,1,0,0,32'd250,0);
      add(1,1,4'hA,5'b00000, 1,0,4'd4,0,0,0,32'd250,0);
      for (int i = 0; i < 10; i++)
         add(1,1,4'h9,5'b00000, 1,0,4'd4,0,0,0,32'd250,0);
      add(1,1,4'hA,5'b00000, 1,0,4'd4,0,0,1,32'd999999999,0);
      add(1,0,4'h0,5'b00010, 1,0,4'd4,0,0,0,32'd999999999,0);
      // withdraw 7, CLEAR, 3
      add(1,1,4'hD,5'b00000, 1,0,4'd4,1,1,0,32'd999999999,0);
      add(1,1,4'h7,5'b00000, 1,0,4'd4,0,1,0,32'd999999999,0);
      add(1,1,4'hB,5'b00000, 1,0,4'd4,0,1,0,32'd999999999,0);
      add(1,1,4'h3,5'b00000, 1,0,4'd4,0,1,0,32'd999999999,0);
      add(1,1,4'hA,5'b00000, 1,0,4'd4,0,1,1,32'd3,0);
      add(1,0,4'h0,5'b00010, 1,0,4'd4,0,1,0,32'd3,0);
      // CANCEL in AMOUNT; re-entry needs card removal
      add(1,1,4'hC,5'b00000, 1,0,4'd4,1,0,0,32'd3,0);
      add(1,1,4'hE,5'b00000, 0,0,4'd4,0,0,0,32'd3,0);
      add(1,0,4'h0,5'b00000, 0,0,4'd4,0,0,0,32'd3,0);
      add(1,1,4'h1,5'b00000, 0,0,4'd4,0,0,0,32'd3,0);
      add(0,0,4'h0,5'b00000, 0,0,4'd4,0,0,0,32'd3,0);
      add(1,0,4'h0,5'b00000, 1,0,4'd4,0,0,0,32'd3,0);
      add(1,1,4'h9,5'b00000, 1,1,4'd9,0,0,0,32'd3,0);
      // digit in the same cycle as card removal is dropped
      add(0,1,4'h4,5'b00000, 0,0,4'd9,0,0,0,32'd3,0);
      add(1,0,4'h0,5'b00000, 1,0,4'd9,0,0,0,32'd3,0);
      add(1,1,4'hA,5'b00000, 1,0,4'd9,0,0,0,32'd3,0);
      add(1,1,4'hF,5'b00000, 1,0,4'd9,0,0,0,32'd3,0);
      add(1,1,4'h1,5'b00000, 1,1,4'd1,0,0,0,32'd3,0);
      add(1,1,4'h2,5'b00000, 1,1,4'd2,0,0,0,32'd3,0);
      add(1,1,4'h3,5'b00000, 1,1,4'd3,0,0,0,32'd3,0);
      add(1,1,4'h4,5'b00000, 1,1,4'd4,0,0,0,32'd3,0);
      // incorrectPin edge outranks CANCEL in the same cycle
      add(1,1,4'hE,5'b10000, 1,0,4'd4,0,0,0,32'd3,0);
      add(1,1,4'h7,5'b10000, 1,1,4'd7,0,0,0,32'd3,0);

      step(0,0,4'h0,5'b00000);
      step(0,0,4'h0,5'b00000);
      chk("reset_state", pk(0,0,4'd0,0,0,0,32'd0,0));
      reset = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].c, tbl[i].k, tbl[i].kc, tbl[i].s);
         chk($sformatf("vec%0d", i), tbl[i].exp);
      end

      // DONE timeout: PIN count is 1 after the table, three more digits finish it
      step(1,1,4'h1,5'b10000);
      step(1,1,4'h2,5'b10000);
      step(1,1,4'h3,5'b10000);
      step(1,1,4'hC,5'b10000);
      chk("deposit_sel", pk(1,0,4'd3,1,0,0,32'd3,0));
      step(1,1,4'h5,5'b10000);
      step(1,1,4'hA,5'b10000);
      chk("amount_5", pk(1,0,4'd3,0,0,1,32'd5,0));
      for (int i = 0; i < TO - 1; i++)
         step(1,0,4'h0,5'b10000);
      step(1,1,4'hC,5'b10000);
      chk("timeout_not_yet", pk(1,0,4'd3,0,0,0,32'd5,0));
      step(1,1,4'hC,5'b10000);
      chk("timeout_exact", pk(1,0,4'd3,1,0,0,32'd5,0));

      // reset in AMOUNT with ENTER pending: nothing strobes
      step(1,1,4'h6,5'b10000);
      reset = 1'b1;
      step(1,1,4'hA,5'b10000);
      chk("reset_mid_amount", pk(0,0,4'd0,0,0,0,32'd0,0));
      reset = 1'b0;
      step(1,0,4'h0,5'b10000);
      chk("after_reset", pk(1,0,4'd0,0,0,0,32'd0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
